// File: rtl/pc_fetch_sequencer.sv
// PC owner and instruction-fetch sequencer: issues req/ready fetches, hands words to decode
// under valid/ready, applies execute redirects and discards wrong-path fetches.
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req_o,
   output logic [31:0]      imem_addr_o,
   input  logic             imem_ready_i,
   input  logic [31:0]      imem_rdata_i,
   output logic             inst_valid_o,
   input  logic             dec_ready_i,
   output logic [31:0]      inst_out_o,
   output logic [31:0]      inst_pc_o,
   input  logic             resolve_valid_i,
   input  logic             is_jmp_i,
   input  logic             is_beq_i,
   input  logic             is_bne_i,
   input  logic             is_zero_i,
   input  logic [31:0]      jmp_target32_i,
   input  logic [31:0]      branch_target_addr_i,
   output logic             align_err_o,
   output logic [CNT_W-1:0] redirect_cnt_o
);

   typedef enum logic [1:0] {StBoot, StFetch, StHold, StDrain} state_e;

   state_e             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        pend_pc_q, pend_pc_d;
   logic               inst_valid_q, inst_valid_d;
   logic [31:0]        inst_out_q, inst_out_d;
   logic [31:0]        inst_pc_q, inst_pc_d;
   logic               align_err_q, align_err_d;
   logic [CNT_W-1:0]   redirect_cnt_q, redirect_cnt_d;

   logic               taken;
   logic [31:0]        target_raw;
   logic [31:0]        target;

   assign taken      = resolve_valid_i &
                       (is_jmp_i | (is_beq_i & is_zero_i) | (is_bne_i & ~is_zero_i));
   assign target_raw = is_jmp_i ? jmp_target32_i : branch_target_addr_i;
   assign target     = target_raw & ~32'h3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StBoot;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q           <= RESET_PC;
         pend_pc_q      <= RESET_PC;
         inst_valid_q   <= 1'b0;
         inst_out_q     <= 32'h0;
         inst_pc_q      <= RESET_PC;
         align_err_q    <= 1'b0;
         redirect_cnt_q <= '0;
      end else begin
         pc_q           <= pc_d;
         pend_pc_q      <= pend_pc_d;
         inst_valid_q   <= inst_valid_d;
         inst_out_q     <= inst_out_d;
         inst_pc_q      <= inst_pc_d;
         align_err_q    <= align_err_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      pend_pc_d      = pend_pc_q;
      inst_valid_d   = inst_valid_q;
      inst_out_d     = inst_out_q;
      inst_pc_d      = inst_pc_q;
      align_err_d    = align_err_q | (taken & (target_raw[1:0] != 2'b00));
      redirect_cnt_d = redirect_cnt_q;
      if (taken && (redirect_cnt_q != {CNT_W{1'b1}})) begin
         redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         StBoot: begin
            if (taken) begin
               pc_d = target;
            end
            state_d = StFetch;
         end
         StFetch: begin
            if (imem_ready_i) begin
               if (taken) begin
                  pc_d = target;
               end else begin
                  inst_out_d   = imem_rdata_i;
                  inst_pc_d    = pc_q;
                  pc_d         = pc_q + 32'd4;
                  inst_valid_d = 1'b1;
                  state_d      = StHold;
               end
            end else if (taken) begin
               // Request already issued must complete unchanged; park the target.
               pend_pc_d = target;
               state_d   = StDrain;
            end
         end
         StHold: begin
            if (taken) begin
               inst_valid_d = 1'b0;
               pc_d         = target;
               state_d      = StFetch;
            end else if (dec_ready_i) begin
               inst_valid_d = 1'b0;
               state_d      = StFetch;
            end
         end
         StDrain: begin
            if (taken) begin
               pend_pc_d = target;
            end
            if (imem_ready_i) begin
               pc_d    = taken ? target : pend_pc_q;
               state_d = StFetch;
            end
         end
         default: state_d = StBoot;
      endcase
   end

   always_comb begin
      imem_req_o = (state_q == StFetch) || (state_q == StDrain);
   end

   // The PC is only advanced or redirected once a request completes, so it is the live address.
   assign imem_addr_o    = pc_q;
   assign inst_valid_o   = inst_valid_q;
   assign inst_out_o     = inst_out_q;
   assign inst_pc_o      = inst_pc_q;
   assign align_err_o    = align_err_q;
   assign redirect_cnt_o = redirect_cnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: a vector table for the sequential/redirect flow plus
// hand-written sequences for stalled fetch, decode back-pressure and reset mid-drain.
module tb_pc_fetch_sequencer;

   localparam logic [31:0] K = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        dec_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        resolve_valid, is_jmp, is_beq, is_bne, is_zero;
   logic [31:0] jmp_target32, branch_target_addr;
   logic        align_err;
   logic [15:0] redirect_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Memory model: word content is a fixed function of its address.
   assign imem_rdata = imem_addr ^ K;

   pc_fetch_sequencer #(.RESET_PC(32'h0040_0000), .CNT_W(16)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .imem_req_o           (imem_req),
      .imem_addr_o          (imem_addr),
      .imem_ready_i         (imem_ready),
      .imem_rdata_i         (imem_rdata),
      .inst_valid_o         (inst_valid),
      .dec_ready_i          (dec_ready),
      .inst_out_o           (inst_out),
      .inst_pc_o            (inst_pc),
      .resolve_valid_i      (resolve_valid),
      .is_jmp_i             (is_jmp),
      .is_beq_i             (is_beq),
      .is_bne_i             (is_bne),
      .is_zero_i            (is_zero),
      .jmp_target32_i       (jmp_target32),
      .branch_target_addr_i (branch_target_addr),
      .align_err_o          (align_err),
      .redirect_cnt_o       (redirect_cnt)
   );

   typedef struct {
      logic        rv, jmp, beq, bne, zero, rdy, dec;
      logic [31:0] jt, bt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_ipc;
      logic [15:0] e_cnt;
      logic        e_align;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(logic rv, logic jmp, logic beq, logic bne, logic zero,
                               logic [31:0] jt, logic [31:0] bt, logic rdy, logic dec,
                               logic e_req, logic [31:0] e_addr, logic e_valid,
                               logic [31:0] e_ipc, logic [15:0] e_cnt, logic e_align);
      vec_t v;
      v.rv = rv; v.jmp = jmp; v.beq = beq; v.bne = bne; v.zero = zero;
      v.jt = jt; v.bt = bt; v.rdy = rdy; v.dec = dec;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_ipc = e_ipc; v.e_cnt = e_cnt; v.e_align = e_align;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic no_resolve();
      resolve_valid = 0; is_jmp = 0; is_beq = 0; is_bne = 0; is_zero = 0;
      jmp_target32 = 32'h0; branch_target_addr = 32'h0;
   endtask

   task automatic chk_core(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid);
      chk({tag, ".req"}, {31'h0, imem_req}, {31'h0, e_req});
      chk({tag, ".addr"}, imem_addr, e_addr);
      chk({tag, ".valid"}, {31'h0, inst_valid}, {31'h0, e_valid});
   endtask

   initial begin
      rst = 1; imem_ready = 0; dec_ready = 0;
      no_resolve();
      // Rows: inputs applied, then one clock, then expected registered outputs.
      vecs[0]  = mk(0,0,0,0,0, 0, 0, 1,1, 1,32'h0040_0000,0,32'h0040_0000,0,0);
      vecs[1]  = mk(0,0,0,0,0, 0, 0, 1,1, 0,32'h0040_0004,1,32'h0040_0000,0,0);
      vecs[2]  = mk(0,0,0,0,0, 0, 0, 1,1, 1,32'h0040_0004,0,32'h0040_0000,0,0);
      vecs[3]  = mk(0,0,0,0,0, 0, 0, 1,1, 0,32'h0040_0008,1,32'h0040_0004,0,0);
      vecs[4]  = mk(0,0,0,0,0, 0, 0, 1,1, 1,32'h0040_0008,0,32'h0040_0004,0,0);
      vecs[5]  = mk(0,0,0,0,0, 0, 0, 1,1, 0,32'h0040_000C,1,32'h0040_0008,0,0);
      // Taken BEQ while holding: drop valid, redirect.
      vecs[6]  = mk(1,0,1,0,1, 0,32'h0040_0100, 1,1, 1,32'h0040_0100,0,32'h0040_0008,1,0);
      vecs[7]  = mk(0,0,0,0,0, 0, 0, 1,1, 0,32'h0040_0104,1,32'h0040_0100,1,0);
      // BNE with zero set is not taken.
      vecs[8]  = mk(1,0,0,1,1, 0,32'h0040_0300, 1,0, 0,32'h0040_0104,1,32'h0040_0100,1,0);
      // Jump without resolve_valid is ignored.
      vecs[9]  = mk(0,1,0,0,0, 32'h0040_0200,0, 1,1, 1,32'h0040_0104,0,32'h0040_0100,1,0);
      vecs[10] = mk(0,1,0,0,0, 32'h0040_0200,0, 1,1, 0,32'h0040_0108,1,32'h0040_0104,1,0);
      // Misaligned jump target.
      vecs[11] = mk(1,1,0,0,0, 32'h0040_0023,0, 1,1, 1,32'h0040_0020,0,32'h0040_0104,2,1);
      vecs[12] = mk(0,0,0,0,0, 0, 0, 1,1, 0,32'h0040_0024,1,32'h0040_0020,2,1);

      step();
      chk("rst.req", {31'h0, imem_req}, 32'h0);
      chk("rst.addr", imem_addr, 32'h0040_0000);
      chk("rst.valid", {31'h0, inst_valid}, 32'h0);
      chk("rst.inst_out", inst_out, 32'h0);
      chk("rst.inst_pc", inst_pc, 32'h0040_0000);
      chk("rst.align", {31'h0, align_err}, 32'h0);
      chk("rst.cnt", {16'h0, redirect_cnt}, 32'h0);

      rst = 0;
      #1;
      chk("boot.req", {31'h0, imem_req}, 32'h0);

      for (int i = 0; i < 13; i++) begin
         resolve_valid = vecs[i].rv; is_jmp = vecs[i].jmp; is_beq = vecs[i].beq;
         is_bne = vecs[i].bne; is_zero = vecs[i].zero;
         jmp_target32 = vecs[i].jt; branch_target_addr = vecs[i].bt;
         imem_ready = vecs[i].rdy; dec_ready = vecs[i].dec;
         step();
         chk_core($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid);
         chk($sformatf("vec%0d.ipc", i), inst_pc, vecs[i].e_ipc);
         chk($sformatf("vec%0d.cnt", i), {16'h0, redirect_cnt}, {16'h0, vecs[i].e_cnt});
         chk($sformatf("vec%0d.align", i), {31'h0, align_err}, {31'h0, vecs[i].e_align});
         if (vecs[i].e_valid) begin
            chk($sformatf("vec%0d.inst", i), inst_out, vecs[i].e_ipc ^ K);
         end
      end

      // align_err stays sticky while the pipeline keeps flowing.
      no_resolve();
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("sticky%0d", i), {31'h0, align_err}, 32'h1);
      end
      chk("flow.addr", imem_addr, 32'h0040_0038);
      chk("flow.ipc", inst_pc, 32'h0040_0034);

      // Stalled fetch with a jump arriving: old request held, data discarded.
      imem_ready = 0;
      step();
      chk_core("stall0", 1, 32'h0040_0038, 0);
      resolve_valid = 1; is_jmp = 1; jmp_target32 = 32'h0040_0040;
      step();
      chk_core("stall1", 1, 32'h0040_0038, 0);
      chk("stall1.cnt", {16'h0, redirect_cnt}, 32'd3);
      no_resolve();
      step();
      chk_core("stall2", 1, 32'h0040_0038, 0);
      imem_ready = 1;
      step();
      chk_core("drain.done", 1, 32'h0040_0040, 0);
      step();
      chk_core("redir.fetch", 0, 32'h0040_0044, 1);
      chk("redir.ipc", inst_pc, 32'h0040_0040);
      chk("redir.inst", inst_out, 32'h0040_0040 ^ K);

      // Decode back-pressure: holding buffer is stable.
      dec_ready = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp%0d.valid", i), {31'h0, inst_valid}, 32'h1);
         chk($sformatf("bp%0d.ipc", i), inst_pc, 32'h0040_0040);
         chk($sformatf("bp%0d.inst", i), inst_out, 32'h0040_0040 ^ K);
      end
      dec_ready = 1;
      step();
      chk_core("bp.release", 1, 32'h0040_0044, 0);

      // Enter DRAIN, then reset asynchronously mid-cycle.
      imem_ready = 0;
      resolve_valid = 1; is_jmp = 1; jmp_target32 = 32'h0040_0080;
      step();
      chk_core("drain.enter", 1, 32'h0040_0044, 0);
      no_resolve();
      #2;
      rst = 1;
      #1;
      chk_core("arst", 0, 32'h0040_0000, 0);
      chk("arst.cnt", {16'h0, redirect_cnt}, 32'h0);
      chk("arst.align", {31'h0, align_err}, 32'h0);
      step();
      rst = 0;
      imem_ready = 1;
      step();
      chk_core("post_rst", 1, 32'h0040_0000, 0);
      step();
      chk_core("post_rst.hold", 0, 32'h0040_0004, 1);
      chk("post_rst.ipc", inst_pc, 32'h0040_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
